// File: rtl/sevenseg_scan.sv
// Four-digit common-anode seven-segment scanner: one shared segment bus, one
// anode per digit, leading-zero blanking, per-digit decimal points and a guard gap.
module sevenseg_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic [3:0] dp_en,
  input  logic       blank_lead,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);

  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;

  logic [3:0] snap_digit [4];
  logic [3:0] snap_dp_en;
  logic       snap_blank_lead;

  logic       frame_start;
  logic       in_guard;
  logic [3:0] cur_digit;
  logic       lz3, lz2, lz1;
  logic       digit_blank;
  logic [6:0] seg_code;
  logic [3:0] an_next;
  logic [6:0] seg_next;
  logic       dp_next;

  // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 shows nothing.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
    case (d)
      4'd0:    bcd_to_seg = 7'b1000000;
      4'd1:    bcd_to_seg = 7'b1111001;
      4'd2:    bcd_to_seg = 7'b0100100;
      4'd3:    bcd_to_seg = 7'b0110000;
      4'd4:    bcd_to_seg = 7'b0011001;
      4'd5:    bcd_to_seg = 7'b0010010;
      4'd6:    bcd_to_seg = 7'b0000010;
      4'd7:    bcd_to_seg = 7'b1111000;
      4'd8:    bcd_to_seg = 7'b0000000;
      4'd9:    bcd_to_seg = 7'b0010000;
      default: bcd_to_seg = 7'b1111111;
    endcase
  endfunction

  assign frame_start = (cnt == '0) && (idx == 2'd0);
  assign in_guard    = (cnt < GUARD_C);

  // Slot counter and digit index.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Inputs are sampled once per frame so a mid-frame change cannot tear the display.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) snap_digit[i] <= 4'd0;
      snap_dp_en      <= 4'd0;
      snap_blank_lead <= 1'b0;
    end else if (frame_start) begin
      snap_digit[0]   <= digit0;
      snap_digit[1]   <= digit1;
      snap_digit[2]   <= digit2;
      snap_digit[3]   <= digit3;
      snap_dp_en      <= dp_en;
      snap_blank_lead <= blank_lead;
    end
  end

  // A zero is "leading" only if every digit to its left is also zero.
  assign lz3 = snap_blank_lead && (snap_digit[3] == 4'd0);
  assign lz2 = lz3 && (snap_digit[2] == 4'd0);
  assign lz1 = lz2 && (snap_digit[1] == 4'd0);

  always_comb begin
    digit_blank = 1'b0;
    case (idx)
      2'd3:    digit_blank = lz3;
      2'd2:    digit_blank = lz2;
      2'd1:    digit_blank = lz1;
      default: digit_blank = 1'b0;
    endcase
  end

  assign cur_digit = snap_digit[idx];
  assign seg_code  = bcd_to_seg(cur_digit);

  always_comb begin
    an_next  = AN_OFF;
    seg_next = SEG_OFF;
    dp_next  = 1'b1;
    if (!in_guard) begin
      an_next = ~(4'b0001 << idx);
      if (!digit_blank) begin
        seg_next = seg_code;
        dp_next  = ~snap_dp_en[idx];
      end
    end
  end

  // Registered pins: no combinational path from any input to the display.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan with REFRESH_DIV=8, GUARD=2: every output
// cycle of each checked frame is compared against hand-derived {an,seg,dp}.
module tb_sevenseg_scan;

  localparam int RD = 8;
  localparam int GD = 2;

  localparam logic [11:0] IDLE = {4'b1111, 7'b1111111, 1'b1};

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] SB = 7'b1111111;

  // clock / reset
  logic clk_in = 1'b0;
  logic reset  = 1'b0;
  always #5 clk_in = ~clk_in;

  logic [3:0] digit0, digit1, digit2, digit3, dp_en;
  logic       blank_lead;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  sevenseg_scan #(.REFRESH_DIV(RD), .GUARD(GD)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .digit0     (digit0),
    .digit1     (digit1),
    .digit2     (digit2),
    .digit3     (digit3),
    .dp_en      (dp_en),
    .blank_lead (blank_lead),
    .an         (an),
    .seg        (seg),
    .dp         (dp)
  );

  // scoreboard
  logic [11:0] exp_q[$];
  logic [3:0]  an_act [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // driver tasks
  task automatic set_inputs(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                            input logic [3:0] d0, input logic [3:0] dpe, input logic bl);
    digit3 = d3; digit2 = d2; digit1 = d1; digit0 = d0; dp_en = dpe; blank_lead = bl;
  endtask

  // Reset with new inputs, check outputs drop at once, release on a falling edge.
  task automatic restart(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                         input logic [3:0] d0, input logic [3:0] dpe, input logic bl);
    @(negedge clk_in);
    reset = 1'b0;
    set_inputs(d3, d2, d1, d0, dpe, bl);
    #1;
    check("rst_idle", {an, seg, dp}, IDLE);
    @(negedge clk_in);
    reset = 1'b1;
  endtask

  // Check frame positions a..b (0..31); s* are active segs per slot, dpl the dp level per slot.
  task automatic check_span(input string tag, input int a, input int b,
                            input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3,
                            input logic [3:0] dpl);
    logic [6:0] s;
    int k, c;
    for (int p = a; p <= b; p++) begin
      k = p / RD;
      c = p % RD;
      case (k)
        0: s = s0;
        1: s = s1;
        2: s = s2;
        default: s = s3;
      endcase
      if (c < GD) exp_q.push_back(IDLE);
      else        exp_q.push_back({an_act[k], s, dpl[k]});
      @(posedge clk_in);
      #1;
      check(tag, {4'h0, an, seg, dp}, {4'h0, exp_q.pop_front()});
    end
  endtask

  initial begin
    set_inputs(4'd9, 4'd8, 4'd7, 4'd6, 4'b1111, 1'b1);

    // Reset values: held low across several edges.
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_in);
      #1;
      check("rst_hold", {4'h0, an, seg, dp}, {4'h0, IDLE});
    end

    // Basic scan, three contiguous frames: exact 8-cycle slots, no idle on wrap, 1-cycle lag.
    set_inputs(4'd1, 4'd2, 4'd3, 4'd4, 4'b0100, 1'b0);
    @(negedge clk_in);
    reset = 1'b1;
    for (int f = 0; f < 3; f++)
      check_span("basic", 0, 31, S4, S3, S2, S1, 4'b1011);

    // Mid-slot asynchronous reset while digit 1 is lit.
    check_span("pre_rst", 0, 12, S4, S3, S2, S1, 4'b1011);
    #2 reset = 1'b0;
    #1 check("rst_async", {4'h0, an, seg, dp}, {4'h0, IDLE});
    @(posedge clk_in);
    #1 check("rst_async_hold", {4'h0, an, seg, dp}, {4'h0, IDLE});
    @(negedge clk_in);
    reset = 1'b1;
    check_span("post_rst", 0, 31, S4, S3, S2, S1, 4'b1011);

    // Leading-zero blanking: blanked digits also drop their dp.
    restart(4'd0, 4'd0, 4'd0, 4'd7, 4'b1111, 1'b1);
    check_span("lz_0007", 0, 31, S7, SB, SB, SB, 4'b1110);
    restart(4'd0, 4'd0, 4'd0, 4'd0, 4'b0000, 1'b1);
    check_span("lz_0000", 0, 31, S0, SB, SB, SB, 4'b1111);
    restart(4'd0, 4'd3, 4'd0, 4'd1, 4'b0010, 1'b1);
    check_span("lz_0301", 0, 31, S1, S0, S3, SB, 4'b1101);
    restart(4'd0, 4'd0, 4'd0, 4'd0, 4'b1000, 1'b0);
    check_span("lz_off", 0, 31, S0, S0, S0, S0, 4'b0111);

    // Invalid BCD code shows blank.
    restart(4'd5, 4'd5, 4'hA, 4'd5, 4'b0000, 1'b0);
    check_span("invalid", 0, 31, S5, SB, S5, S5, 4'b1111);

    // No tearing: change inputs during slot 2, effect only in the next frame.
    restart(4'd0, 4'd0, 4'd0, 4'd3, 4'b0000, 1'b0);
    check_span("tear_a", 0, 18, S3, S0, S0, S0, 4'b1111);
    set_inputs(4'd0, 4'd0, 4'd0, 4'd8, 4'b1111, 1'b1);
    check_span("tear_b", 19, 31, S3, S0, S0, S0, 4'b1111);
    check_span("tear_next", 0, 31, S8, SB, SB, SB, 4'b1110);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
